trunci_buffered: RTL

- Registered unsigned-truncation unit for dataflow tokens; the inverse of the zero-extend operator.
- Accepts an INPUT_TYPE-bit token and emits its low OUTPUT_TYPE bits through a 2-slot elastic buffer.
- The buffer gives full throughput and a registered ins_ready, so the block breaks both the valid path and the ready path.
- Sits between a wide producer and a narrow consumer in elastic circuits.

---
 rtl/trunci_buffered.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/trunci_buffered.sv
`default_nettype none
// ============================================================================
// Module      : trunci_buffered
// Description : Registered unsigned truncation for elastic dataflow tokens.
//               Keeps the low OUTPUT_TYPE bits of each INPUT_TYPE-bit token
//               and passes it through a 2-slot elastic buffer (main + skid).
//               The buffer gives full throughput, and ins_ready is decoded
//               from registered state only, so both the valid path and the
//               ready path are broken.
//
// Parameters  : INPUT_TYPE  - input width  (INPUT_TYPE >= OUTPUT_TYPE)
//               OUTPUT_TYPE - output width (>= 1)
//
// Ports       : clk        in   clock, rising edge
//               rst        in   synchronous reset, active-low
//               ins        in   input token data [INPUT_TYPE]
//               ins_valid  in   input token valid
//               ins_ready  out  block can accept a token
//               outs       out  truncated data [OUTPUT_TYPE]
//               outs_valid out  output token valid
//               outs_ready in   consumer accepts token
//               outs_ovf   out  discarded upper bits were nonzero
//                               (only with TRUNC_OVF_FLAG_EN defined)
//
// Optional    : TRUNC_OVF_FLAG_EN - adds outs_ovf, stored with each token.
//
// Revision    : 1.0 - initial release
// ============================================================================
module trunci_buffered #(
  parameter int INPUT_TYPE  = 64,
  parameter int OUTPUT_TYPE = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INPUT_TYPE-1:0]  ins,
  input  logic                   ins_valid,
  output logic                   ins_ready,
  output logic [OUTPUT_TYPE-1:0] outs,
  output logic                   outs_valid,
  input  logic                   outs_ready
`ifdef TRUNC_OVF_FLAG_EN
  ,
  output logic                   outs_ovf
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [OUTPUT_TYPE-1:0] main_data;
  logic [OUTPUT_TYPE-1:0] skid_data;
  logic [OUTPUT_TYPE-1:0] trunc_data;

  logic in_fire;
  logic out_fire;
  logic load_main;
  logic main_from_skid;
  logic load_skid;

  // Upper bits are dropped here and never reach a register.
  assign trunc_data = ins[OUTPUT_TYPE-1:0];

`ifdef TRUNC_OVF_FLAG_EN
  logic main_ovf;
  logic skid_ovf;
  logic ovf_in;

  generate
    if (INPUT_TYPE > OUTPUT_TYPE) begin : g_ovf_detect
      assign ovf_in = |ins[INPUT_TYPE-1:OUTPUT_TYPE];
    end else begin : g_ovf_none
      // Nothing is discarded, so there can be no overflow.
      assign ovf_in = 1'b0;
    end
  endgenerate

  assign outs_ovf = main_ovf;
`else
  generate
    if (INPUT_TYPE > OUTPUT_TYPE) begin : g_upper_unused
      // Discarded bits are intentionally left unobserved.
      logic unused_upper;
      assign unused_upper = ^ins[INPUT_TYPE-1:OUTPUT_TYPE];
    end
  endgenerate
`endif

  // Ready depends on registered state only: no path from outs_ready.
  assign ins_ready  = (state != FULL);
  assign outs_valid = (state != EMPTY);
  assign outs       = main_data;

  assign in_fire  = ins_valid && ins_ready;
  assign out_fire = outs_valid && outs_ready;

  always_comb begin
    state_next     = state;
    load_main      = 1'b0;
    main_from_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      EMPTY: begin
        if (in_fire) begin
          state_next = ONE;
          load_main  = 1'b1;
        end
      end
      ONE: begin
        if (in_fire && !out_fire) begin
          state_next = FULL;
          load_skid  = 1'b1;
        end else if (in_fire && out_fire) begin
          // Consumer drains main while the new token replaces it.
          load_main  = 1'b1;
        end else if (!in_fire && out_fire) begin
          state_next = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          state_next     = ONE;
          load_main      = 1'b1;
          main_from_skid = 1'b1;
        end
      end
      default: begin
        state_next = EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= EMPTY;
      main_data <= '0;
      skid_data <= '0;
    end else begin
      state <= state_next;
      if (load_main) begin
        main_data <= main_from_skid ? skid_data : trunc_data;
      end
      if (load_skid) begin
        skid_data <= trunc_data;
      end
    end
  end

`ifdef TRUNC_OVF_FLAG_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      main_ovf <= 1'b0;
      skid_ovf <= 1'b0;
    end else begin
      if (load_main) begin
        main_ovf <= main_from_skid ? skid_ovf : ovf_in;
      end
      if (load_skid) begin
        skid_ovf <= ovf_in;
      end
    end
  end
`endif

endmodule
`default_nettype wire
